// File: rtl/pfu_if.sv
//------------------------------------------------------------------------------
// pfu_if
//   Bundle of everything the prefetch unit exchanges with its neighbours. The
//   bundle covers the global clock enable, the execute-stage vector request,
//   the pipelined instruction bus, and the decode-side dav/ack port.
//   Modports:
//     slave  : the prefetch unit itself
//     master : its environment (execute stage, instruction bus, decode)
//   Start-of-fetch codes: `SOFID_RANGE / `SOFID_1ST / `SOFID_RUN.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef SOFID_RANGE
`define SOFID_RANGE 1:0
`endif
`ifndef SOFID_1ST
`define SOFID_1ST 2'b01
`endif
`ifndef SOFID_RUN
`define SOFID_RUN 2'b00
`endif

interface pfu_if;
  logic                clk_en_i;
  logic                exs_pc_wr_i;
  logic [31:0]         exs_pc_din_i;
  logic                ireqvalid_o;
  logic                ireqready_i;
  logic [31:0]         ireqaddr_o;
  logic                irspvalid_i;
  logic                irsprerr_i;
  logic [31:0]         irspdata_i;
  logic                ids_dav_o;
  logic                ids_ack_i;
  logic [`SOFID_RANGE] ids_sofid_o;
  logic [31:0]         ids_ins_o;
  logic                ids_ferr_o;
  logic [31:0]         ids_pc_o;

  modport slave (
    input  clk_en_i, exs_pc_wr_i, exs_pc_din_i,
    input  ireqready_i, irspvalid_i, irsprerr_i, irspdata_i,
    input  ids_ack_i,
    output ireqvalid_o, ireqaddr_o,
    output ids_dav_o, ids_sofid_o, ids_ins_o, ids_ferr_o, ids_pc_o
  );

  modport master (
    output clk_en_i, exs_pc_wr_i, exs_pc_din_i,
    output ireqready_i, irspvalid_i, irsprerr_i, irspdata_i,
    output ids_ack_i,
    input  ireqvalid_o, ireqaddr_o,
    input  ids_dav_o, ids_sofid_o, ids_ins_o, ids_ferr_o, ids_pc_o
  );
endinterface

`default_nettype wire

// File: rtl/pfu.sv
//------------------------------------------------------------------------------
// pfu
//   Prefetch unit. It issues sequential word fetches on a pipelined
//   instruction bus and buffers the in-order responses (instruction, PC and
//   error flag) in a DEPTH-entry FIFO. The FIFO head is presented to decode
//   through dav/ack. A PC write from execute redirects fetch, flushes the
//   FIFO, and discards responses still in flight. The first instruction
//   after reset or a redirect is tagged `SOFID_1ST.
//   Ports:
//     clk_i    : clock, all state on the rising edge
//     reset_i  : asynchronous active-high reset
//     ifc      : pfu_if.slave (clock enable, vector, bus, decode port)
//   Optional feature: define PFU_FERR_HALT_EN to stop fetching after a bus
//   error until the next vector.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef SOFID_RANGE
`define SOFID_RANGE 1:0
`endif
`ifndef SOFID_1ST
`define SOFID_1ST 2'b01
`endif
`ifndef SOFID_RUN
`define SOFID_RUN 2'b00
`endif

module pfu #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 4
) (
  input  wire logic clk_i,
  input  wire logic reset_i,
  pfu_if.slave      ifc
);

  localparam int unsigned    AW      = $clog2(DEPTH);
  localparam logic [AW+1:0]  DEPTH_W = (AW+2)'(DEPTH);

  logic [31:0]         req_pc;
  logic [31:0]         rsp_pc;
  logic [AW:0]         outstanding;
  logic [AW:0]         discard_cnt;
  logic [AW:0]         fifo_count;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                sof_flag;
  logic                halt;

  logic [31:0]         ins_mem  [DEPTH];
  logic [31:0]         pc_mem   [DEPTH];
  logic                ferr_mem [DEPTH];
  logic [`SOFID_RANGE] sof_mem  [DEPTH];

  logic                vec;
  logic [31:0]         vec_pc;
  logic                rsp;
  logic                req_valid;
  logic                req_fire;
  logic                push;
  logic                pop;
  logic [AW+1:0]       credit_sum;
  logic                unused_din_bits;

  assign vec             = ifc.clk_en_i & ifc.exs_pc_wr_i;
  assign vec_pc          = {ifc.exs_pc_din_i[31:2], 2'b00};
  assign unused_din_bits = &{1'b0, ifc.exs_pc_din_i[1:0]};
  assign rsp             = ifc.clk_en_i & ifc.irspvalid_i;

  // Buffered plus in-flight entries never exceed DEPTH, so a push always
  // finds room.
  assign credit_sum = {1'b0, fifo_count} + {1'b0, outstanding};
  assign req_valid  = ifc.clk_en_i & ~ifc.exs_pc_wr_i & ~halt & ~reset_i &
                      (credit_sum < DEPTH_W);
  assign req_fire   = req_valid & ifc.ireqready_i;

  // A vector wins over a same-cycle write or pop.
  assign push = rsp & (discard_cnt == '0) & ~vec;
  assign pop  = ifc.clk_en_i & ifc.ids_ack_i & (fifo_count != '0) & ~vec;

  assign ifc.ireqvalid_o = req_valid;
  assign ifc.ireqaddr_o  = req_pc;
  assign ifc.ids_dav_o   = (fifo_count != '0);
  assign ifc.ids_ins_o   = ins_mem[rd_ptr];
  assign ifc.ids_pc_o    = pc_mem[rd_ptr];
  assign ifc.ids_ferr_o  = ferr_mem[rd_ptr];
  assign ifc.ids_sofid_o = sof_mem[rd_ptr];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      req_pc   <= RESET_ADDR;
      rsp_pc   <= RESET_ADDR;
      sof_flag <= 1'b1;
    end else if (vec) begin
      req_pc   <= vec_pc;
      rsp_pc   <= vec_pc;
      sof_flag <= 1'b1;
    end else begin
      if (req_fire) req_pc <= req_pc + 32'd4;
      if (push) begin
        rsp_pc   <= rsp_pc + 32'd4;
        sof_flag <= 1'b0;
      end
    end
  end

  // Responses still owed to requests issued before a vector are counted in
  // discard_cnt and dropped; a response landing in the vector cycle itself
  // is already gone, hence the subtraction.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding + (AW+1)'(req_fire) - (AW+1)'(rsp);
      if (vec)
        discard_cnt <= outstanding - (AW+1)'(rsp);
      else if (rsp && (discard_cnt != '0))
        discard_cnt <= discard_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (vec) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage carries no reset; its contents are meaningless while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      ins_mem[wr_ptr]  <= ifc.irspdata_i;
      pc_mem[wr_ptr]   <= rsp_pc;
      ferr_mem[wr_ptr] <= ifc.irsprerr_i;
      sof_mem[wr_ptr]  <= sof_flag ? `SOFID_1ST : `SOFID_RUN;
    end
  end

`ifdef PFU_FERR_HALT_EN
  // Fetching stops after an erroneous instruction is buffered; responses
  // already in flight still land.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      halt <= 1'b0;
    else if (vec)
      halt <= 1'b0;
    else if (push && ifc.irsprerr_i)
      halt <= 1'b1;
  end
`else
  assign halt = 1'b0;
`endif

endmodule

`default_nettype wire
